lsu_cache_ctrl: RTL and testbench

//  Parametrised load/store unit for the processor: direct-mapped, write-through, no-write-allocate cache
//  in front of the shared memory bus. Bus access uses a req/ack/valid handshake to the memory controller.

---
 rtl/lsu_cache_ctrl.sv | 157 +++++++++++++++
 tb/tb_lsu_cache_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lsu_cache_ctrl.sv
// Load/store unit with a direct-mapped, write-through, no-write-allocate cache.
// Misses and all stores go to memory over a req/ack/valid bus, with a timeout on the handshake.
module lsu_cache_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LINES   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              err,
  input  logic              bus_busy,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              bus_valid,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rvalid
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REQ     = 3'd1;
  localparam logic [2:0] GRANT   = 3'd2;
  localparam logic [2:0] XFER    = 3'd3;
  localparam logic [2:0] WAIT_RD = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state;
  logic              is_load;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [CNT_W-1:0]  tcnt;
  logic              hit_r;
  logic              err_r;

  logic [LINES-1:0]  line_vld;
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  logic [IDX_W-1:0]  in_idx, a_idx;
  logic [TAG_W-1:0]  in_tag, a_tag;
  logic              in_hit, a_hit, timed_out;

  assign in_idx    = addr[IDX_W-1:0];
  assign in_tag    = addr[ADDR_W-1:IDX_W];
  assign a_idx     = a_addr[IDX_W-1:0];
  assign a_tag     = a_addr[ADDR_W-1:IDX_W];
  assign in_hit    = line_vld[in_idx] && (line_tag[in_idx] == in_tag);
  assign a_hit     = line_vld[a_idx] && (line_tag[a_idx] == a_tag);
  assign timed_out = (tcnt == CNT_W'(TIMEOUT - 1));

  assign done      = (state == DONE);
  assign hit       = done & hit_r;
  assign err       = done & err_r;
  assign bus_rw    = is_load;
  assign bus_addr  = a_addr;
  assign bus_wdata = a_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_load   <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= '0;
      tcnt      <= '0;
      hit_r     <= 1'b0;
      err_r     <= 1'b0;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_valid <= 1'b0;
      line_vld  <= '0;
    end else begin
      case (state)
        IDLE: begin
          hit_r <= 1'b0;
          err_r <= 1'b0;
          if (start && (op == OP_LOAD || op == OP_STORE)) begin
            a_addr  <= addr;
            a_wdata <= wdata;
            is_load <= (op == OP_LOAD);
            if (op == OP_LOAD && in_hit) begin
              rdata <= line_data[in_idx];
              hit_r <= 1'b1;
              state <= DONE;
            end else begin
              tcnt  <= '0;
              state <= REQ;
            end
          end
        end
        REQ: begin
          // bus_req stays high through GRANT so it falls exactly as bus_valid rises
          if (bus_req && bus_ack) begin
            state <= GRANT;
          end else if (timed_out) begin
            bus_req <= 1'b0;
            err_r   <= 1'b1;
            rdata   <= '0;
            state   <= DONE;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
            if (!bus_busy) bus_req <= 1'b1;
          end
        end
        GRANT: begin
          bus_req   <= 1'b0;
          bus_valid <= 1'b1;
          state     <= XFER;
        end
        XFER: begin
          bus_valid <= 1'b0;
          if (is_load) begin
            tcnt  <= '0;
            state <= WAIT_RD;
          end else begin
            if (a_hit) line_data[a_idx] <= a_wdata;
            state <= DONE;
          end
        end
        WAIT_RD: begin
          if (bus_rvalid) begin
            line_vld[a_idx]  <= 1'b1;
            line_tag[a_idx]  <= a_tag;
            line_data[a_idx] <= bus_rdata;
            rdata            <= bus_rdata;
            state            <= DONE;
          end else if (timed_out) begin
            err_r <= 1'b1;
            rdata <= '0;
            state <= DONE;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_cache_ctrl.sv
// Directed bench for lsu_cache_ctrl: a per-op bus responder drives ack/rvalid and
// records what the DUT put on the bus; results are compared against hand-computed values.
module tb_lsu_cache_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op = 4'h0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       done, hit, err;
  logic [7:0] rdata;
  logic       bus_busy = 1'b0, bus_ack = 1'b0, bus_rvalid = 1'b0;
  logic       bus_req, bus_valid, bus_rw;
  logic [7:0] bus_addr, bus_wdata;
  logic [7:0] bus_rdata = 8'h00;

  int checks = 0;
  int failures = 0;

  localparam logic [3:0] LD = 4'b1000;
  localparam logic [3:0] ST = 4'b1001;

  lsu_cache_ctrl #(.DATA_W(8), .ADDR_W(8), .LINES(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .hit(hit), .err(err),
    .bus_busy(bus_busy), .bus_req(bus_req), .bus_ack(bus_ack), .bus_valid(bus_valid),
    .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // results of the last run_op
  bit       r_done, r_hit, r_err, r_rw, r_reqseen, r_req_busy, r_post_rst, r_req_at_done;
  logic [7:0] r_rdata, r_vaddr, r_vwdata;
  int       r_lat, r_nvalid, r_first_req;

  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input bit ack_en, input int busy_n,
                        input int rst_at, input int maxc);
    int rv_at;
    rv_at = -1;
    r_done = 0; r_hit = 0; r_err = 0; r_rw = 0; r_reqseen = 0; r_req_busy = 0;
    r_post_rst = 0; r_req_at_done = 0; r_rdata = 0; r_vaddr = 0; r_vwdata = 0;
    r_lat = 0; r_nvalid = 0; r_first_req = 0;
    @(negedge clk);
    op = o; addr = a; wdata = wd; start = 1'b1; bus_busy = (busy_n > 0);
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      start = 1'b0; op = 4'h0; addr = 8'hFF; wdata = 8'hEE;
      bus_ack = 1'b0; bus_rvalid = 1'b0;
      if (bus_req) begin
        r_reqseen = 1;
        if (r_first_req == 0) r_first_req = c;
        if (c <= busy_n) r_req_busy = 1;
      end
      if (rst_at > 0 && c > rst_at && (bus_req || bus_valid || done)) r_post_rst = 1;
      if (bus_valid) begin
        r_nvalid++; r_rw = bus_rw; r_vaddr = bus_addr; r_vwdata = bus_wdata;
        if (bus_rw) rv_at = c + 2;
      end
      if (done) begin
        r_done = 1; r_lat = c; r_hit = hit; r_err = err; r_rdata = rdata;
        r_req_at_done = bus_req;
        break;
      end
      bus_busy = (c < busy_n);
      if (ack_en && bus_req) bus_ack = 1'b1;
      if (c == rv_at) begin bus_rvalid = 1'b1; bus_rdata = rd; end
      reset = (c == rst_at);
    end
    bus_ack = 1'b0; bus_rvalid = 1'b0; bus_busy = 1'b0; reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outs", {18'd0, done, hit, err, bus_req, bus_valid, bus_rw, rdata}, 32'd0);

    // 1: cold load miss
    run_op(LD, 8'h12, 8'h00, 8'h5A, 1, 0, 0, 40);
    chk("t1_done", r_done, 1);
    chk("t1_hit", r_hit, 0);
    chk("t1_rdata", r_rdata, 8'h5A);
    chk("t1_nvalid", r_nvalid, 1);
    chk("t1_rw", r_rw, 1);
    chk("t1_addr", r_vaddr, 8'h12);
    chk("t1_lat", r_lat, 7);

    // 2: load hit
    run_op(LD, 8'h12, 8'h00, 8'h00, 1, 0, 0, 40);
    chk("t2_hit", r_hit, 1);
    chk("t2_rdata", r_rdata, 8'h5A);
    chk("t2_lat", r_lat, 1);
    chk("t2_noreq", r_reqseen, 0);

    // 3: store hit writes through and updates the line
    run_op(ST, 8'h12, 8'hC3, 8'h00, 1, 0, 0, 40);
    chk("t3_done", r_done, 1);
    chk("t3_rw", r_rw, 0);
    chk("t3_addr", r_vaddr, 8'h12);
    chk("t3_wdata", r_vwdata, 8'hC3);
    chk("t3_lat", r_lat, 5);
    run_op(LD, 8'h12, 8'h00, 8'h00, 1, 0, 0, 40);
    chk("t3_ld_hit", r_hit, 1);
    chk("t3_ld_rdata", r_rdata, 8'hC3);

    // 4: store miss does not allocate
    run_op(ST, 8'h34, 8'h11, 8'h00, 1, 0, 0, 40);
    chk("t4_st_nvalid", r_nvalid, 1);
    run_op(LD, 8'h34, 8'h00, 8'h22, 1, 0, 0, 40);
    chk("t4_ld_hit", r_hit, 0);
    chk("t4_ld_rw", r_rw, 1);
    chk("t4_ld_rdata", r_rdata, 8'h22);

    // eviction: 0x14 shares index 4 with 0x34
    run_op(LD, 8'h14, 8'h00, 8'h66, 1, 0, 0, 40);
    chk("ev_fill_hit", r_hit, 0);
    run_op(LD, 8'h34, 8'h00, 8'h23, 1, 0, 0, 40);
    chk("ev_hit", r_hit, 0);
    chk("ev_rdata", r_rdata, 8'h23);

    // unsupported op is ignored
    run_op(4'b0001, 8'h12, 8'h00, 8'h00, 1, 0, 0, 10);
    chk("badop_done", r_done, 0);
    chk("badop_req", r_reqseen, 0);

    // 5: bus busy for 5 cycles
    run_op(LD, 8'h40, 8'h00, 8'h9C, 1, 5, 0, 40);
    chk("t5_req_busy", r_req_busy, 0);
    chk("t5_first_req", r_first_req, 6);
    chk("t5_rdata", r_rdata, 8'h9C);

    // 6: no ack -> timeout
    run_op(ST, 8'h12, 8'h77, 8'h00, 0, 0, 0, 100);
    chk("t6_done", r_done, 1);
    chk("t6_err", r_err, 1);
    chk("t6_rdata", r_rdata, 8'h00);
    chk("t6_lat", (r_lat >= 64 && r_lat <= 66), 1);
    chk("t6_req_low", r_req_at_done, 0);
    run_op(LD, 8'h12, 8'h00, 8'h00, 1, 0, 0, 40);
    chk("t6_cache_kept", r_rdata, 8'hC3);

    // reset during WAIT_RD aborts and clears the cache
    run_op(LD, 8'h77, 8'h00, 8'hAB, 1, 0, 5, 15);
    chk("rst_nodone", r_done, 0);
    chk("rst_quiet", r_post_rst, 0);
    run_op(LD, 8'h77, 8'h00, 8'h99, 1, 0, 0, 40);
    chk("rst_ld_miss", r_hit, 0);
    chk("rst_ld_rdata", r_rdata, 8'h99);
    run_op(LD, 8'h12, 8'h00, 8'h44, 1, 0, 0, 40);
    chk("rst_old_miss", r_hit, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
